dcache_ctrl: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache. Sits between the CPU load/store stage
//  and data_mem. Hits complete with zero wait states. On a miss it drives data_mem's

---
 rtl/dcache_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Define DCACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module dcache_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int INDEX_W  = 3,
  parameter int OFFSET_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              busy_wait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_busy_wait
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int BLK   = 1 << OFFSET_W;

  typedef enum logic [1:0] {IDLE, WB, FILL, UPD} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0]   data_q [LINES][BLK];
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [LINES-1:0]    valid_q, dirty_q;

  logic [OFFSET_W-1:0] k_q, k_d;
  logic [INDEX_W-1:0]  idx_q, idx_d;
  logic [TAG_W-1:0]    rtag_q, rtag_d;
  logic                mrd_q, mrd_d;
  logic                mwr_q, mwr_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [DATA_W-1:0]   mwd_q, mwd_d;

  logic [TAG_W-1:0]    a_tag;
  logic [INDEX_W-1:0]  a_idx;
  logic [OFFSET_W-1:0] a_off;
  logic                rd_req, wr_req, req;
  logic                hit, hit_wr, last;
  logic                fill_we, upd;

  assign a_tag  = address[ADDR_W-1 -: TAG_W];
  assign a_idx  = address[OFFSET_W +: INDEX_W];
  assign a_off  = address[OFFSET_W-1:0];
  assign rd_req = read & ~write;
  assign wr_req = write & ~read;
  assign req    = rd_req | wr_req;
  assign hit    = (state_q == IDLE) && valid_q[a_idx]
                  && (tag_q[a_idx] == a_tag);
  assign hit_wr = wr_req && hit;
  assign last   = (k_q == {OFFSET_W{1'b1}});

  assign busy_wait      = req && ((state_q != IDLE) || !hit);
  assign read_data      = (rd_req && hit) ? data_q[a_idx][a_off] : '0;
  assign mem_read       = mrd_q;
  assign mem_write      = mwr_q;
  assign mem_address    = maddr_q;
  assign mem_write_data = mwd_q;

  // Miss sequencing: write back victim bytes, refill, then install the tag.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    idx_d   = idx_q;
    rtag_d  = rtag_q;
    mrd_d   = mrd_q;
    mwr_d   = mwr_q;
    maddr_d = maddr_q;
    mwd_d   = mwd_q;
    fill_we = 1'b0;
    upd     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req && !hit) begin
          idx_d   = a_idx;
          rtag_d  = a_tag;
          k_d     = '0;
          state_d = (valid_q[a_idx] && dirty_q[a_idx]) ? WB : FILL;
        end
      end
      WB: begin
        if (!mwr_q) begin
          mwr_d   = 1'b1;
          maddr_d = {tag_q[idx_q], idx_q, k_q};
          mwd_d   = data_q[idx_q][k_q];
        end else if (!mem_busy_wait) begin
          mwr_d = 1'b0;
          k_d   = k_q + 1'b1;
          if (last) state_d = FILL;
        end
      end
      FILL: begin
        if (!mrd_q) begin
          mrd_d   = 1'b1;
          maddr_d = {rtag_q, idx_q, k_q};
        end else if (!mem_busy_wait) begin
          mrd_d   = 1'b0;
          fill_we = 1'b1;
          k_d     = k_q + 1'b1;
          if (last) state_d = UPD;
        end
      end
      UPD: begin
        upd     = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // Control state and registered memory-side outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      idx_q   <= '0;
      rtag_q  <= '0;
      mrd_q   <= 1'b0;
      mwr_q   <= 1'b0;
      maddr_q <= '0;
      mwd_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
      rtag_q  <= rtag_d;
      mrd_q   <= mrd_d;
      mwr_q   <= mwr_d;
      maddr_q <= maddr_d;
      mwd_q   <= mwd_d;
    end
  end

  // Line status bits; reset invalidates every line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (upd) begin
      valid_q[idx_q] <= 1'b1;
      dirty_q[idx_q] <= 1'b0;
    end else if (hit_wr) begin
      dirty_q[a_idx] <= 1'b1;
    end
  end

  // Data and tag storage (not reset).
  always_ff @(posedge clk) begin
    if (fill_we) data_q[idx_q][k_q] <= mem_read_data;
    else if (hit_wr) data_q[a_idx][a_off] <= write_data;
    if (upd) tag_q[idx_q] <= rtag_q;
  end

`ifdef DCACHE_STATS_EN
  logic        miss_pend_q;
  logic [15:0] hit_cnt_q, miss_cnt_q;

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  // Classify each completed request by whether its first lookup hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miss_pend_q <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else if (req && !hit && (state_q == IDLE)) begin
      miss_pend_q <= 1'b1;
    end else if (req && hit) begin
      miss_pend_q <= 1'b0;
      if (miss_pend_q) begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
      end else begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: memory responder, table vectors,
// multi-cycle corner cases and a randomized model check.
module tb_dcache_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       read = 1'b0;
  logic       write = 1'b0;
  logic [7:0] address = '0;
  logic [7:0] write_data = '0;
  logic [7:0] read_data;
  logic       busy_wait;
  logic       mem_read, mem_write;
  logic [7:0] mem_address, mem_write_data, mem_read_data;
  logic       mem_busy_wait;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk(clk), .rst(rst), .read(read), .write(write),
    .address(address), .write_data(write_data),
    .read_data(read_data), .busy_wait(busy_wait),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_busy_wait(mem_busy_wait)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // memory responder
  logic [7:0] mem [256];
  typedef struct {bit we; logic [7:0] a; logic [7:0] d;} xfer_t;
  xfer_t xlog[$];
  int   stall = 0;
  int   wcnt = 0;
  bit   pend = 1'b0;
  bit   just_done = 1'b0;
  bit   p_we = 1'b0;
  logic [7:0] p_addr = '0, p_wd = '0;

  assign mem_read_data = mem[mem_address];
  assign mem_busy_wait = (mem_read || mem_write) && (wcnt < stall);

  always @(posedge clk) begin
    if (just_done)
      chk("mem_gap", int'(mem_read | mem_write), 0);
    just_done <= 1'b0;
    if (mem_read || mem_write) begin
      chk("mem_excl", int'(mem_read & mem_write), 0);
      if (pend) begin
        chk("stable_addr", int'(mem_address), int'(p_addr));
        chk("stable_dir", int'(mem_write), int'(p_we));
        if (p_we)
          chk("stable_wd", int'(mem_write_data), int'(p_wd));
      end
      if (mem_busy_wait) begin
        pend   <= 1'b1;
        p_addr <= mem_address;
        p_wd   <= mem_write_data;
        p_we   <= mem_write;
        wcnt   <= wcnt + 1;
      end else begin
        chk("stall_len", wcnt, stall);
        pend      <= 1'b0;
        wcnt      <= 0;
        just_done <= 1'b1;
        xlog.push_back('{mem_write, mem_address,
                         mem_write ? mem_write_data : mem[mem_address]});
        if (mem_write) mem[mem_address] = mem_write_data;
      end
    end else begin
      if (pend && rst) begin
        n_cmp++;
        n_bad++;
        $display("FAIL req_dropped: request fell at %0h while stalled", p_addr);
      end
      pend <= 1'b0;
      wcnt <= 0;
    end
  end

  // reference model: CPU-visible memory plus a line directory
  logic [7:0] rv [256];
  bit         dv [8];
  bit         dd [8];
  logic [2:0] dt [8];

  task automatic m_reset();
    for (int i = 0; i < 8; i++) begin
      dv[i] = 1'b0;
      dd[i] = 1'b0;
    end
  endtask

  function automatic bit m_hit(input logic [7:0] a);
    return dv[a[4:2]] && (dt[a[4:2]] == a[7:5]);
  endfunction

  task automatic m_commit(input bit wr, input logic [7:0] a,
                          input logic [7:0] d, input bit hit);
    int idx;
    idx = int'(a[4:2]);
    if (wr) rv[a] = d;
    dd[idx] = wr || (hit && dd[idx]);
    dv[idx] = 1'b1;
    dt[idx] = a[7:5];
  endtask

  task automatic do_reset();
    read  = 1'b0;
    write = 1'b0;
    rst   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mrd", int'(mem_read), 0);
    chk("rst_mwr", int'(mem_write), 0);
    chk("rst_maddr", int'(mem_address), 0);
    chk("rst_mwd", int'(mem_write_data), 0);
    chk("rst_busy", int'(busy_wait), 0);
    chk("rst_rdata", int'(read_data), 0);
    rst = 1'b1;
  endtask

  task automatic access(input bit wr, input logic [7:0] a,
                        input logic [7:0] d,
                        output logic [7:0] rd, output bit fb);
    int cyc;
    cyc = 0;
    @(negedge clk);
    read       = !wr;
    write      = wr;
    address    = a;
    write_data = d;
    #1;
    fb = busy_wait;
    while (busy_wait && cyc < 400) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (busy_wait) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: addr %0h still busy", a);
    end
    rd = read_data;
    @(posedge clk);
    #1;
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic chk_log(input string nm, input int nwr,
                         input logic [7:0] wb, input int nrd,
                         input logic [7:0] rb);
    chk({nm, "_nxfer"}, xlog.size(), nwr + nrd);
    if (xlog.size() == nwr + nrd) begin
      for (int i = 0; i < nwr + nrd; i++) begin
        bit         ew;
        logic [7:0] ea;
        ew = (i < nwr);
        ea = ew ? wb + 8'(i) : rb + 8'(i - nwr);
        chk({nm, "_xkind"}, int'(xlog[i].we), int'(ew));
        chk({nm, "_xaddr"}, int'(xlog[i].a), int'(ea));
        chk({nm, "_xdata"}, int'(xlog[i].d), int'(rv[ea]));
      end
    end
  endtask

  task automatic check_access(input string nm, input bit wr,
                              input logic [7:0] a, input logic [7:0] d);
    bit         hit, fb;
    int         nwr, nrd;
    logic [7:0] wb, rb, rd;
    hit = m_hit(a);
    nwr = (!hit && dv[a[4:2]] && dd[a[4:2]]) ? 4 : 0;
    nrd = hit ? 0 : 4;
    wb  = {dt[a[4:2]], a[4:2], 2'b00};
    rb  = {a[7:2], 2'b00};
    xlog.delete();
    access(wr, a, d, rd, fb);
    chk({nm, "_busy"}, int'(fb), int'(!hit));
    chk_log(nm, nwr, wb, nrd, rb);
    if (!wr) chk({nm, "_rdata"}, int'(rd), int'(rv[a]));
    m_commit(wr, a, d, hit);
  endtask

  typedef struct {
    bit         wr;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] rd;
    bit         busy;
    int         nwr;
    logic [7:0] wb;
    int         nrd;
    logic [7:0] rb;
  } vec_t;

  initial begin
    vec_t       tbl [4];
    logic [7:0] rd;
    bit         fb, hit, wr;
    logic [7:0] a, d;
    int         c;

    tbl[0] = '{1'b0, 8'h02, 8'h00, 8'h33, 1'b1, 0, 8'h00, 4, 8'h00};
    tbl[1] = '{1'b1, 8'h01, 8'hAA, 8'h00, 1'b0, 0, 8'h00, 0, 8'h00};
    tbl[2] = '{1'b0, 8'h01, 8'h00, 8'hAA, 1'b0, 0, 8'h00, 0, 8'h00};
    tbl[3] = '{1'b0, 8'h21, 8'h00, 8'h66, 1'b1, 4, 8'h00, 4, 8'h20};

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h00] = 8'h11; mem[8'h01] = 8'h22;
    mem[8'h02] = 8'h33; mem[8'h03] = 8'h44;
    mem[8'h20] = 8'h55; mem[8'h21] = 8'h66;
    mem[8'h22] = 8'h77; mem[8'h23] = 8'h88;
    for (int i = 0; i < 256; i++) rv[i] = mem[i];
    m_reset();
    do_reset();

    for (int i = 0; i < 4; i++) begin
      hit = m_hit(tbl[i].a);
      xlog.delete();
      access(tbl[i].wr, tbl[i].a, tbl[i].d, rd, fb);
      chk($sformatf("vec%0d_busy", i), int'(fb), int'(tbl[i].busy));
      chk_log($sformatf("vec%0d", i), tbl[i].nwr, tbl[i].wb,
              tbl[i].nrd, tbl[i].rb);
      if (!tbl[i].wr)
        chk($sformatf("vec%0d_rdata", i), int'(rd), int'(tbl[i].rd));
      m_commit(tbl[i].wr, tbl[i].a, tbl[i].d, hit);
`ifdef DCACHE_STATS_EN
      if (i == 2) begin
        chk("stat_hits", int'(hit_count), 2);
        chk("stat_miss", int'(miss_count), 1);
      end
`endif
    end

    stall = 3;
    check_access("stall_w", 1'b1, 8'h04, 8'h5A);
    check_access("stall_r", 1'b0, 8'h44, 8'h00);
    stall = 0;

    xlog.delete();
    @(negedge clk);
    read    = 1'b1;
    address = 8'h08;
    c = 0;
    while (c < 40 && !(xlog.size() == 1 && mem_read)) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("abort_progress", xlog.size(), 1);
    rst = 1'b0;
    #1;
    chk("abort_mrd", int'(mem_read), 0);
    chk("abort_mwr", int'(mem_write), 0);
    read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_reset();
    check_access("abort_retry", 1'b0, 8'h08, 8'h00);

    check_access("both_pre", 1'b0, 8'h00, 8'h00);
    xlog.delete();
    @(negedge clk);
    read       = 1'b1;
    write      = 1'b1;
    address    = 8'h00;
    write_data = 8'hEE;
    #1;
    chk("both_busy0", int'(busy_wait), 0);
    repeat (3) @(negedge clk);
    #1;
    chk("both_busy1", int'(busy_wait), 0);
    chk("both_traffic", xlog.size(), 0);
    read  = 1'b0;
    write = 1'b0;
    check_access("both_post", 1'b0, 8'h00, 8'h00);

    do_reset();
    m_reset();
    for (int n = 0; n < 300; n++) begin
      stall = $urandom_range(0, 2);
      a     = {3'($urandom_range(0, 3)), 5'($urandom)};
      wr    = 1'($urandom_range(0, 1));
      d     = 8'($urandom);
      check_access("rnd", wr, a, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
